// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the RV32I ALU issue stage: EXECOP codes, opcodes,
// exec payload and immediate extraction helpers.
package alu_issue_stage_pkg;

  localparam int unsigned XLEN_W   = 32;
  localparam int unsigned ILEN_W   = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned EXECOP_W = 4;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [EXECOP_W-1:0] {
    EXEC_ADD  = 4'd0,
    EXEC_SUB  = 4'd1,
    EXEC_SLL  = 4'd2,
    EXEC_SLT  = 4'd3,
    EXEC_SLTU = 4'd4,
    EXEC_XOR  = 4'd5,
    EXEC_SRL  = 4'd6,
    EXEC_SRA  = 4'd7,
    EXEC_OR   = 4'd8,
    EXEC_AND  = 4'd9
  } execop_e;

  // Everything the ALU needs for one issued instruction.
  typedef struct packed {
    execop_e             ctrl;
    logic [XLEN_W-1:0]   op1;
    logic [XLEN_W-1:0]   op2;
    logic [REG_AW-1:0]   rd;
    logic                wen;
  } exec_payload_t;

  // Sign-extended I-type immediate.
  function automatic logic [XLEN_W-1:0] imm_i(input logic [ILEN_W-1:0] instr);
    return {{(XLEN_W-12){instr[31]}}, instr[31:20]};
  endfunction

  // U-type immediate, low 12 bits zero.
  function automatic logic [XLEN_W-1:0] imm_u(input logic [ILEN_W-1:0] instr);
    return {instr[31:12], 12'b0};
  endfunction

  // Zero-extended shift amount of the immediate shift forms.
  function automatic logic [XLEN_W-1:0] shamt_i(input logic [ILEN_W-1:0] instr);
    return XLEN_W'(instr[24:20]);
  endfunction

  // funct3 to EXECOP for the base (funct7 == 0) encodings.
  function automatic execop_e base_op(input logic [2:0] funct3);
    execop_e op;
    case (funct3)
      3'b000:  op = EXEC_ADD;
      3'b001:  op = EXEC_SLL;
      3'b010:  op = EXEC_SLT;
      3'b011:  op = EXEC_SLTU;
      3'b100:  op = EXEC_XOR;
      3'b101:  op = EXEC_SRL;
      3'b110:  op = EXEC_OR;
      default: op = EXEC_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_stage_scoreboard.sv
// Register busy bits: set on issue, clear on writeback, wiped on flush.
module alu_issue_stage_scoreboard
  import alu_issue_stage_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_set_en,
  input  logic [REG_AW-1:0] i_set_addr,
  input  logic              i_clr_en,
  input  logic [REG_AW-1:0] i_clr_addr,
  input  logic [REG_AW-1:0] i_rs1_addr,
  input  logic [REG_AW-1:0] i_rs2_addr,
  output logic              o_rs1_busy_c,
  output logic              o_rs2_busy_c
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;

  // Next busy vector: clear first so a same-rd set wins; x0 never busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_en) w_busy_nxt[i_clr_addr] = 1'b0;
    if (i_set_en) w_busy_nxt[i_set_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
    if (i_flush) w_busy_nxt = '0;
  end

  // Busy register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_busy <= '0;
    else          r_busy <= w_busy_nxt;
  end

  assign o_rs1_busy_c = r_busy[i_rs1_addr];
  assign o_rs2_busy_c = r_busy[i_rs2_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage for ALU-class opcodes with a RAW scoreboard.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_W
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            flush_i,
  input  logic            wb_valid_i,
  input  logic [4:0]      wb_rd_i,
  output logic            exec_valid_o,
  input  logic            exec_ready_i,
  output logic [3:0]      exec_ctrl_o,
  output logic [XLEN-1:0] exec_operand1_o,
  output logic [XLEN-1:0] exec_operand2_o,
  output logic [4:0]      exec_rd_o,
  output logic            exec_wen_o,
  output logic            illegal_o
);

  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic [6:0]        w_funct7;
  logic [REG_AW-1:0] w_rd;
  logic              w_legal;
  logic              w_use_rs1;
  logic              w_use_rs2;
  logic              w_rs1_busy;
  logic              w_rs2_busy;
  logic              w_stall;
  logic              w_accept;
  logic              w_issue;
  exec_payload_t     w_payload;

  exec_payload_t     r_exec;
  logic              r_exec_valid;
  logic              r_illegal;

  assign w_opcode   = instr_i[6:0];
  assign w_funct3   = instr_i[14:12];
  assign w_funct7   = instr_i[31:25];
  assign w_rd       = instr_i[11:7];
  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];

  // Decode legality, EXECOP, operands and which sources gate issue.
  always_comb begin
    w_legal        = 1'b0;
    w_use_rs1      = 1'b0;
    w_use_rs2      = 1'b0;
    w_payload.ctrl = EXEC_ADD;
    w_payload.op1  = '0;
    w_payload.op2  = '0;
    w_payload.rd   = w_rd;
    w_payload.wen  = (w_rd != '0);
    case (w_opcode)
      OPC_OP: begin
        w_use_rs1     = 1'b1;
        w_use_rs2     = 1'b1;
        w_payload.op1 = rs1_data_i;
        w_payload.op2 = rs2_data_i;
        if (w_funct7 == F7_BASE) begin
          w_legal        = 1'b1;
          w_payload.ctrl = base_op(w_funct3);
        end else if (w_funct7 == F7_ALT && w_funct3 == 3'b000) begin
          w_legal        = 1'b1;
          w_payload.ctrl = EXEC_SUB;
        end else if (w_funct7 == F7_ALT && w_funct3 == 3'b101) begin
          w_legal        = 1'b1;
          w_payload.ctrl = EXEC_SRA;
        end
      end
      OPC_OP_IMM: begin
        w_use_rs1      = 1'b1;
        w_legal        = 1'b1;
        w_payload.op1  = rs1_data_i;
        w_payload.op2  = imm_i(instr_i);
        w_payload.ctrl = base_op(w_funct3);
        if (w_funct3 == 3'b001) begin
          w_payload.op2 = shamt_i(instr_i);
          w_legal       = (w_funct7 == F7_BASE);
        end else if (w_funct3 == 3'b101) begin
          w_payload.op2 = shamt_i(instr_i);
          if (w_funct7 == F7_ALT) w_payload.ctrl = EXEC_SRA;
          else                    w_legal        = (w_funct7 == F7_BASE);
        end
      end
      OPC_LUI: begin
        w_legal       = 1'b1;
        w_payload.op2 = imm_u(instr_i);
      end
      OPC_AUIPC: begin
        w_legal       = 1'b1;
        w_payload.op1 = pc_i;
        w_payload.op2 = imm_u(instr_i);
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  // Only a present, legal instruction can be held back by a pending source.
  assign w_stall = instr_valid_i && w_legal &&
                   ((w_use_rs1 && w_rs1_busy) || (w_use_rs2 && w_rs2_busy));

  assign instr_ready_o = !w_stall && (!r_exec_valid || exec_ready_i) && !flush_i;
  assign w_accept      = instr_valid_i && instr_ready_o;
  assign w_issue       = w_accept && w_legal;

  alu_issue_stage_scoreboard u_scoreboard (
    .i_clk        (clk_i),
    .i_rst_n      (rst_ni),
    .i_flush      (flush_i),
    .i_set_en     (w_issue && w_payload.wen),
    .i_set_addr   (w_rd),
    .i_clr_en     (wb_valid_i),
    .i_clr_addr   (wb_rd_i),
    .i_rs1_addr   (rs1_addr_o),
    .i_rs2_addr   (rs2_addr_o),
    .o_rs1_busy_c (w_rs1_busy),
    .o_rs2_busy_c (w_rs2_busy)
  );

  // Exec output register: load on issue, drop when drained or flushed, else hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_exec_valid <= 1'b0;
      r_exec       <= '0;
      r_illegal    <= 1'b0;
    end else begin
      r_illegal <= w_accept && !w_legal;
      if (flush_i) begin
        r_exec_valid <= 1'b0;
      end else if (w_issue) begin
        r_exec_valid <= 1'b1;
        r_exec       <= w_payload;
      end else if (exec_ready_i) begin
        r_exec_valid <= 1'b0;
      end
    end
  end

  assign exec_valid_o    = r_exec_valid;
  assign exec_ctrl_o     = r_exec.ctrl;
  assign exec_operand1_o = r_exec.op1;
  assign exec_operand2_o = r_exec.op2;
  assign exec_rd_o       = r_exec.rd;
  assign exec_wen_o      = r_exec.wen;
  assign illegal_o       = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed test-plan sequences, then randomized
// traffic checked every cycle against an instruction-level reference model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        in_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        ex_ready;

  logic        instr_ready_o;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic        exec_valid_o;
  logic [3:0]  exec_ctrl_o;
  logic [31:0] exec_operand1_o;
  logic [31:0] exec_operand2_o;
  logic [4:0]  exec_rd_o;
  logic        exec_wen_o;
  logic        illegal_o;

  alu_issue_stage dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .instr_valid_i   (in_valid),
    .instr_ready_o   (instr_ready_o),
    .instr_i         (instr),
    .pc_i            (pc),
    .rs1_addr_o      (rs1_addr_o),
    .rs2_addr_o      (rs2_addr_o),
    .rs1_data_i      (rs1_data),
    .rs2_data_i      (rs2_data),
    .flush_i         (flush),
    .wb_valid_i      (wb_valid),
    .wb_rd_i         (wb_rd),
    .exec_valid_o    (exec_valid_o),
    .exec_ready_i    (ex_ready),
    .exec_ctrl_o     (exec_ctrl_o),
    .exec_operand1_o (exec_operand1_o),
    .exec_operand2_o (exec_operand2_o),
    .exec_rd_o       (exec_rd_o),
    .exec_wen_o      (exec_wen_o),
    .illegal_o       (illegal_o)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model state: in-flight ALU slot, pending destinations, illegal pulse.
  logic [31:0] regs [32];
  logic [3:0]  base_tab [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
  bit          m_valid;
  bit          m_ill;
  logic [31:0] m_busy;
  logic [73:0] m_pay;
  bit          obs_rdy;
  bit          last_acc;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [73:0] dut_pay();
    return {exec_ctrl_o, exec_operand1_o, exec_operand2_o, exec_rd_o, exec_wen_o};
  endfunction

  // Instruction semantics from the ISA tables: legality, EXECOP, operands, sources read.
  function automatic void ref_decode(input logic [31:0] ins, input logic [31:0] ipc,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output bit ok, output logic [3:0] op,
                                     output logic [31:0] x, output logic [31:0] y,
                                     output bit n1, output bit n2);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    ok = 0; op = 4'd0; x = 32'd0; y = 32'd0; n1 = 0; n2 = 0;
    if (opc == 7'h33) begin
      n1 = 1; n2 = 1; x = a; y = b;
      if (f7 == 7'h00) begin
        ok = 1; op = base_tab[f3];
      end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
        ok = 1; op = (f3 == 3'd0) ? 4'd1 : 4'd7;
      end
    end else if (opc == 7'h13) begin
      n1 = 1; x = a;
      if (f3 == 3'd1 || f3 == 3'd5) begin
        y = {27'd0, ins[24:20]};
        if (f7 == 7'h00) begin
          ok = 1; op = base_tab[f3];
        end else if (f7 == 7'h20 && f3 == 3'd5) begin
          ok = 1; op = 4'd7;
        end
      end else begin
        ok = 1; op = base_tab[f3]; y = 32'($signed(ins[31:20]));
      end
    end else if (opc == 7'h37) begin
      ok = 1; y = ins & 32'hFFFF_F000;
    end else if (opc == 7'h17) begin
      ok = 1; x = ipc; y = ins & 32'hFFFF_F000;
    end
  endfunction

  task automatic model_reset();
    m_valid = 0; m_ill = 0; m_busy = '0; m_pay = '0; last_acc = 0;
  endtask

  // One clock: check handshake before the edge, advance the model, check outputs after.
  task automatic cycle();
    bit ok, n1, n2, stall, rdy, acc;
    logic [3:0]  op;
    logic [31:0] x, y;
    logic [4:0]  s1, s2, d;
    s1 = instr[19:15];
    s2 = instr[24:20];
    d  = instr[11:7];
    rs1_data = regs[s1];
    rs2_data = regs[s2];
    #1;
    ref_decode(instr, pc, rs1_data, rs2_data, ok, op, x, y, n1, n2);
    stall = in_valid && ok && ((n1 && m_busy[s1]) || (n2 && m_busy[s2]));
    rdy   = !stall && (!m_valid || ex_ready) && !flush;
    acc   = in_valid && rdy;
    obs_rdy = instr_ready_o;
    chk("instr_ready", 96'(instr_ready_o), 96'(rdy));
    chk("rs_addr", 96'({rs1_addr_o, rs2_addr_o}), 96'({s1, s2}));
    @(posedge clk);
    #1;
    if (flush) begin
      m_valid = 0; m_busy = '0; m_ill = 0;
    end else begin
      m_ill = acc && !ok;
      if (wb_valid) m_busy[wb_rd] = 1'b0;
      if (acc && ok) begin
        m_valid = 1;
        m_pay   = {op, x, y, d, (d != 5'd0)};
        if (d != 5'd0) m_busy[d] = 1'b1;
      end else if (ex_ready) begin
        m_valid = 0;
      end
    end
    last_acc = acc;
    chk("exec_valid", 96'(exec_valid_o), 96'(m_valid));
    chk("illegal", 96'(illegal_o), 96'(m_ill));
    chk("exec_payload", 96'(dut_pay()), 96'(m_pay));
  endtask

  function automatic logic [31:0] gen_instr();
    logic [6:0] f7;
    logic [4:0] r1, r2, rd;
    logic [2:0] f3;
    int unsigned sel, fsel;
    sel  = $urandom_range(0, 9);
    fsel = $urandom_range(0, 5);
    f7 = (fsel < 3) ? 7'h00 : (fsel < 5) ? 7'h20 : 7'($urandom);
    r1 = 5'($urandom_range(0, 7));
    r2 = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    f3 = 3'($urandom);
    case (sel)
      0, 1, 2: return {f7, r2, r1, f3, rd, 7'h33};
      3, 4:    return {7'($urandom), 5'($urandom), r1, f3, rd, 7'h13};
      5:       return {f7, 5'($urandom), r1, (fsel[0] ? 3'd1 : 3'd5), rd, 7'h13};
      6:       return {20'($urandom), rd, 7'h37};
      7:       return {20'($urandom), rd, 7'h17};
      8:       return $urandom;
      default: return 32'h0000_0073;
    endcase
  endfunction

  logic [73:0] held;

  initial begin
    rst_ni = 1'b0; in_valid = 0; instr = '0; pc = 32'h0000_1000;
    rs1_data = '0; rs2_data = '0; flush = 0; wb_valid = 0; wb_rd = '0; ex_ready = 1;
    foreach (regs[i]) regs[i] = 32'd0;
    regs[1] = 32'd5; regs[2] = 32'd7; regs[3] = 32'd9;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_exec_valid", 96'(exec_valid_o), 96'(0));
    chk("rst_payload", 96'(dut_pay()), 96'(0));
    chk("rst_illegal", 96'(illegal_o), 96'(0));
    chk("rst_ready", 96'(instr_ready_o), 96'(1));
    rst_ni = 1'b1;
    cycle();

    // add x3,x1,x2
    in_valid = 1; instr = 32'h0020_81B3;
    cycle();
    chk("add_payload", 96'(dut_pay()), 96'({4'd0, 32'd5, 32'd7, 5'd3, 1'b1}));
    // add x4,x3,x3 waits on x3
    instr = 32'h0031_8233;
    cycle();
    chk("raw_stall0", 96'(obs_rdy), 96'(0));
    wb_valid = 1; wb_rd = 5'd3;
    cycle();
    chk("raw_stall_wb", 96'(obs_rdy), 96'(0));
    wb_valid = 0;
    cycle();
    chk("raw_release", 96'(obs_rdy), 96'(1));
    chk("raw_payload", 96'(dut_pay()), 96'({4'd0, 32'd9, 32'd9, 5'd4, 1'b1}));
    // srai x3,x1,3
    instr = 32'h4030_D193;
    cycle();
    chk("srai_payload", 96'(dut_pay()), 96'({4'd7, 32'd5, 32'd3, 5'd3, 1'b1}));
    in_valid = 0;
    cycle();
    chk("drain", 96'(exec_valid_o), 96'(0));

    // Backpressure: addi x5,x0,1 then addi x6,x0,2 waiting
    in_valid = 1; instr = 32'h0010_0293; ex_ready = 0;
    cycle();
    held = dut_pay();
    chk("bp_first", 96'(held), 96'({4'd0, 32'd0, 32'd1, 5'd5, 1'b1}));
    instr = 32'h0020_0313;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_ready_low", 96'(obs_rdy), 96'(0));
      chk("bp_hold", 96'({exec_valid_o, dut_pay()}), 96'({1'b1, held}));
    end
    ex_ready = 1;
    cycle();
    chk("bp_second", 96'(dut_pay()), 96'({4'd0, 32'd0, 32'd2, 5'd6, 1'b1}));
    in_valid = 0;
    cycle();

    // ecall
    in_valid = 1; instr = 32'h0000_0073;
    cycle();
    chk("ecall_pulse", 96'({illegal_o, exec_valid_o}), 96'({1'b1, 1'b0}));
    in_valid = 0;
    cycle();
    chk("ecall_pulse_end", 96'(illegal_o), 96'(0));

    // Flush while valid and stalled: lui x8 held, add x7,x5,x6 pending on x5/x6
    in_valid = 1; instr = 32'h1234_5437; ex_ready = 0;
    cycle();
    chk("lui_payload", 96'(dut_pay()), 96'({4'd0, 32'd0, 32'h1234_5000, 5'd8, 1'b1}));
    instr = 32'h0062_83B3;
    cycle();
    chk("flush_pre_stall", 96'(obs_rdy), 96'(0));
    flush = 1;
    cycle();
    chk("flush_valid", 96'(exec_valid_o), 96'(0));
    flush = 0; ex_ready = 1;
    cycle();
    chk("flush_busy_cleared", 96'({exec_valid_o, exec_rd_o}), 96'({1'b1, 5'd7}));

    // Asynchronous reset with an instruction held
    instr = 32'h0050_0493; ex_ready = 0;
    cycle();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", 96'(exec_valid_o), 96'(0));
    chk("arst_payload", 96'(dut_pay()), 96'(0));
    model_reset();
    in_valid = 0; ex_ready = 1;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    cycle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (!(in_valid && !last_acc) || $urandom_range(0, 9) == 0) begin
        in_valid = ($urandom_range(0, 3) != 0);
        instr    = gen_instr();
        pc       = $urandom & 32'hFFFF_FFFC;
      end
      if ($urandom_range(0, 3) == 0) regs[$urandom_range(1, 31)] = $urandom;
      ex_ready = ($urandom_range(0, 9) < 7);
      wb_valid = ($urandom_range(0, 9) < 4);
      wb_rd    = 5'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 29) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode/issue stage for the SamsunCore RV32I integer path. It accepts fetched instructions on a valid/ready handshake and decodes the ALU-class opcodes (OP, OP-IMM, LUI, AUIPC) into a 4-bit EXECOP control plus two resolved 32-bit operands. It holds a register scoreboard so that no instruction issues while a source register is still pending writeback. Its registered output drives the ALU's ctrl/operand inputs directly, one cycle behind acceptance.

## Interface
- `XLEN`, 32: datapath width. Only 32 is supported.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `instr_valid_i` in 1: instruction present on the fetch side.
- `instr_ready_o` out 1: stage accepts this cycle.
- `instr_i` in 32: instruction word.
- `pc_i` in 32: PC of `instr_i`.
- `rs1_addr_o`, `rs2_addr_o` out 5 each: register-file read addresses, combinational from `instr_i`.
- `rs1_data_i`, `rs2_data_i` in 32 each: combinational register-file read data.
- `flush_i` in 1: kill held and incoming instructions.
- `wb_valid_i` in 1, `wb_rd_i` in 5: writeback retire; clears the scoreboard bit for `wb_rd_i`.
- `exec_valid_o` out 1, `exec_ready_i` in 1: issue handshake toward the ALU.
- `exec_ctrl_o` out 4: EXECOP code.
- `exec_operand1_o`, `exec_operand2_o` out 32: ALU operands.
- `exec_rd_o` out 5, `exec_wen_o` out 1: destination register and write enable.
- `illegal_o` out 1: one-cycle pulse when a non-ALU or malformed instruction is consumed.

## Operation
- **EXECOP codes:** ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
- **OP (0110011):**
  - funct7=0000000 selects by funct3: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - funct7=0100000 is legal only with funct3=000 (SUB) or 101 (SRA).
  - Operands are rs1 and rs2.
- **OP-IMM (0010011):**
  - Operand1 is rs1; operand2 is the sign-extended I-immediate.
  - SLLI requires funct7=0.
  - SRLI/SRAI select on funct7 (0000000 / 0100000); operand2 = {27'b0, shamt}.
  - There is no SUBI.
- **LUI (0110111):** ADD, operand1 = 0, operand2 = {imm[31:12], 12'b0}.
- **AUIPC (0010111):** ADD, operand1 = `pc_i`, operand2 = U-immediate.
- **Illegal decode:** any other opcode or funct combination is consumed, pulses `illegal_o`, issues nothing and sets no busy bit.
- **Scoreboard:** 32 busy bits.
  - Issue with rd≠0 sets busy[rd]; `exec_wen_o` = (rd≠0).
  - `wb_valid_i` clears busy[`wb_rd_i`].
  - busy[0] is always 0.
- **Stall:** a legal instruction stalls while busy[rs1] or, for OP, busy[rs2] is set. LUI and AUIPC never stall.
- **Accept condition:** `instr_ready_o` = !stall && (!exec_valid_o || exec_ready_i) && !flush_i.

## Timing
- **Reset values:**
  - `exec_valid_o`=0, `exec_ctrl_o`=0, operands=0, `exec_rd_o`=0, `exec_wen_o`=0, `illegal_o`=0.
  - Scoreboard is all clear; `instr_ready_o` is 1 whenever `instr_valid_i` is low.
- **Latency:** an instruction accepted at edge N appears on `exec_*` after edge N. Throughput is 1 per cycle when there are no hazards.
- **Output hold:** `exec_*` hold stable while exec_valid_o && !exec_ready_i.
- **Scoreboard timing:**
  - Busy set and clear take effect at the edge; stall evaluation uses registered bits, so there is no same-cycle writeback bypass.
  - Set and clear of the same rd at the same edge: set wins.
- **Flush:** at the next edge `exec_valid_o`=0, all busy bits clear, nothing is accepted that cycle, and `illegal_o` is suppressed.
- **Reset mid-operation:** held instruction and scoreboard are discarded immediately, asynchronously.

## Structure
- EXECOP codes and opcode constants live in the shared definitions header (`include/Definitions.vh`) used by the ALU.
- Immediate extraction (I/U forms) belongs in package functions.
- One sub-module: `scoreboard` (busy bits, set/clear ports, two combinational source lookups).

## Test plan
- **ADD issue:** `instr_i`=0x002081B3 (add x3,x1,x2), x1=5, x2=7.
  - Next cycle: exec_ctrl_o=0, operands 5/7, exec_rd_o=3, exec_wen_o=1.
  - busy[3]=1.
- **SRAI:** `instr_i`=0x4030D193 (srai x3,x1,3).
  - ctrl=7, operand2=0x00000003.
- **RAW hazard:** after the add to x3, present 0x00318233 (add x4,x3,x3).
  - `instr_ready_o`=0 until the cycle after wb_valid_i=1/wb_rd_i=3.
  - Then it issues with ctrl=0, rd=4.
- **Backpressure:** exec_ready_i=0 for 3 cycles with a second instruction waiting.
  - `exec_*` stay stable and `instr_ready_o`=0.
  - Both instructions issue in order once exec_ready_i=1.
- **Illegal:** `instr_i`=0x00000073 (ecall).
  - One-cycle `illegal_o`; exec_valid_o stays 0; scoreboard unchanged.
- **Flush and reset:** flush_i while valid and stalled clears exec_valid_o and all busy bits. Asserting rst_ni=0 mid-stream returns outputs to 0 without waiting for a clock edge.
